// File: rtl/round_countdown.sv
// Round time limit: counts down whole seconds with pause/resume/abort and
// flags expiry (level plus one-cycle strobe) for the game FSM.
module round_countdown #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int WIDTH         = 8,
  parameter int WARN_SECS     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] time_left,
  output logic             running,
  output logic             expired,
  output logic             expire_pulse,
  output logic             warning,
  output logic             blink
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0]    PRESC_HALF = PW'(TICKS_PER_SEC / 2);
  localparam logic [WIDTH-1:0] WARN_V     = WIDTH'(WARN_SECS);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] time_left_q, time_left_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             expire_pulse_q, expire_pulse_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      time_left_q    <= '0;
      presc_q        <= '0;
      expire_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      time_left_q    <= time_left_d;
      presc_q        <= presc_d;
      expire_pulse_q <= expire_pulse_d;
    end
  end

  // Command priority: abort > load > start > pause > tick.
  always_comb begin
    state_d        = state_q;
    time_left_d    = time_left_q;
    presc_d        = presc_q;
    expire_pulse_d = 1'b0;
    if (abort) begin
      state_d     = S_IDLE;
      time_left_d = '0;
      presc_d     = '0;
    end else if (load) begin
      state_d     = S_IDLE;
      time_left_d = load_value;
      presc_d     = '0;
    end else if (start && state_q == S_IDLE) begin
      presc_d = '0;
      if (time_left_q != '0) begin
        state_d = S_RUNNING;
      end else begin
        state_d        = S_EXPIRED;
        expire_pulse_d = 1'b1;
      end
    end else if (start && state_q == S_PAUSED) begin
      state_d = S_RUNNING;
    end else if (pause && state_q == S_RUNNING) begin
      state_d = S_PAUSED;
    end else if (state_q == S_RUNNING) begin
      if (presc_q == PRESC_LAST) begin
        presc_d     = '0;
        time_left_d = time_left_q - ONE;
        // Leaving 1 means this tick ends the round; time_left cannot wrap.
        if (time_left_q == ONE) begin
          state_d        = S_EXPIRED;
          expire_pulse_d = 1'b1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_comb begin
    time_left    = time_left_q;
    running      = (state_q == S_RUNNING);
    expired      = (state_q == S_EXPIRED);
    expire_pulse = expire_pulse_q;
    warning      = (state_q == S_RUNNING || state_q == S_PAUSED) &&
                   (time_left_q != '0) && (time_left_q <= WARN_V);
    blink        = warning && (presc_q < PRESC_HALF);
  end

endmodule

// File: tb/tb_round_countdown.sv
// Directed bench for round_countdown with TICKS_PER_SEC=4, WARN_SECS=2;
// expected values are hand-derived cycle counts from the start-accept edge.
module tb_round_countdown;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         load, start, pause, abort;
  logic [W-1:0] load_value;
  logic [W-1:0] time_left;
  logic         running, expired, expire_pulse, warning, blink;

  int n_cmp = 0;
  int n_bad = 0;

  round_countdown #(.TICKS_PER_SEC(4), .WIDTH(W), .WARN_SECS(2)) dut (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .abort(abort),
    .time_left(time_left), .running(running), .expired(expired),
    .expire_pulse(expire_pulse), .warning(warning), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clock edges; outputs are sampled 1 time unit after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_value = v; load = 1'b1; step(1); load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1; step(1); pause = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 0; start = 0; pause = 0; abort = 0; load_value = '0;
    step(2);
    chk("rst_time", time_left, 0);
    chk("rst_run", running, 0);
    chk("rst_exp", expired, 0);
    chk("rst_pulse", expire_pulse, 0);
    chk("rst_warn", warning, 0);
    chk("rst_blink", blink, 0);
    #2 rst = 1'b0;
    step(1);

    // 1: load 3 run to expiry
    do_load(8'd3);
    chk("t1_loaded", time_left, 3);
    do_start();
    chk("t1_run", running, 1);
    chk("t1_t0", time_left, 3);
    chk("t1_warn0", warning, 0);
    step(3);
    chk("t1_t3", time_left, 3);
    step(1);
    chk("t1_t4", time_left, 2);
    chk("t1_warn4", warning, 1);
    chk("t1_blink4", blink, 1);
    step(4);
    chk("t1_t8", time_left, 1);
    step(3);
    chk("t1_warn11", warning, 1);
    chk("t1_exp11", expired, 0);
    step(1);
    chk("t1_t12", time_left, 0);
    chk("t1_exp12", expired, 1);
    chk("t1_pulse12", expire_pulse, 1);
    chk("t1_warn12", warning, 0);
    chk("t1_run12", running, 0);
    step(1);
    chk("t1_pulse13", expire_pulse, 0);
    chk("t1_exp13", expired, 1);

    // 2: pause with prescaler at 2, resume
    do_load(8'd5);
    do_start();
    step(6);
    do_pause();
    chk("t2_paused_run", running, 0);
    chk("t2_paused_t", time_left, 4);
    step(20);
    chk("t2_hold_t", time_left, 4);
    chk("t2_hold_run", running, 0);
    chk("t2_hold_warn", warning, 0);
    do_start();
    chk("t2_resume_run", running, 1);
    chk("t2_r0", time_left, 4);
    step(1);
    chk("t2_r1", time_left, 4);
    step(1);
    chk("t2_r2", time_left, 3);

    // 3: start with zero time
    do_load(8'd0);
    do_start();
    chk("t3_exp", expired, 1);
    chk("t3_pulse", expire_pulse, 1);
    chk("t3_run", running, 0);
    step(1);
    chk("t3_pulse1", expire_pulse, 0);
    chk("t3_run1", running, 0);

    // 4: abort beats load in the same cycle
    do_load(8'd2);
    do_start();
    step(1);
    chk("t4_pre_t", time_left, 2);
    abort = 1'b1; load = 1'b1; load_value = 8'd9;
    step(1);
    abort = 1'b0; load = 1'b0;
    chk("t4_abort_t", time_left, 0);
    chk("t4_abort_run", running, 0);
    chk("t4_abort_exp", expired, 0);
    chk("t4_abort_pulse", expire_pulse, 0);
    step(1);
    chk("t4_abort_pulse1", expire_pulse, 0);
    do_load(8'd9);
    chk("t4_load_t", time_left, 9);
    chk("t4_load_run", running, 0);

    // 5: asynchronous reset mid-second
    do_load(8'd4);
    do_start();
    step(2);
    rst = 1'b1;
    #1;
    chk("t5_rst_t", time_left, 0);
    chk("t5_rst_run", running, 0);
    chk("t5_rst_warn", warning, 0);
    step(1);
    chk("t5_rst_pulse", expire_pulse, 0);
    #2 rst = 1'b0;
    step(1);
    do_start();
    chk("t5_exp", expired, 1);
    chk("t5_pulse", expire_pulse, 1);

    // 6: blink phase and freeze under pause
    do_load(8'd2);
    do_start();
    chk("t6_warn_p0", warning, 1);
    chk("t6_blink_p0", blink, 1);
    step(1);
    chk("t6_blink_p1", blink, 1);
    step(1);
    chk("t6_blink_p2", blink, 0);
    step(1);
    chk("t6_blink_p3", blink, 0);
    step(1);
    chk("t6_t_dec", time_left, 1);
    chk("t6_blink_q0", blink, 1);
    step(2);
    chk("t6_blink_q2", blink, 0);
    do_pause();
    chk("t6_pause_blink", blink, 0);
    chk("t6_pause_warn", warning, 1);
    step(5);
    chk("t6_hold_blink", blink, 0);
    chk("t6_hold_warn", warning, 1);
    chk("t6_hold_t", time_left, 1);
    do_start();
    chk("t6_r0_blink", blink, 0);
    step(1);
    chk("t6_r1_t", time_left, 1);
    step(1);
    chk("t6_r2_t", time_left, 0);
    chk("t6_r2_exp", expired, 1);
    chk("t6_r2_warn", warning, 0);
    chk("t6_r2_blink", blink, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
